// File: rtl/fsm_moore_pkg.sv
// Shared definitions for the serial 1010 Moore detector: state encoding,
// state width and the reference pattern used by bench models.
package fsm_moore_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3,
        S_1010 = 3'd4
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1010;

    function automatic logic is_match(input state_t s);
        return (s == S_1010);
    endfunction

endpackage

// File: rtl/fsm_moore_verilog.sv
// Moore detector for the serial pattern 1010; the flag is a pure decode of the
// registered state, so it never follows i_data_in combinationally.
module fsm_moore_verilog
    import fsm_moore_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_data_in,
    output logic o_data_out
);

    state_t state;
    state_t state_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = S_IDLE;
        case (state)
            S_IDLE:  state_next = i_data_in ? S_1   : S_IDLE;
            S_1:     state_next = i_data_in ? S_1   : S_10;
            S_10:    state_next = i_data_in ? S_101 : S_IDLE;
            S_101:   state_next = i_data_in ? S_1   : S_1010;
            S_1010: begin
                // The trailing "10" of a match is reused as the next prefix only when overlapping.
                if (i_data_in) begin
                    state_next = (OVERLAP != 0) ? S_101 : S_1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_data_out = is_match(state);
    end

endmodule

// File: tb/tb_fsm_moore_verilog.sv
// Directed and random checks of the 1010 detector, run side by side with
// OVERLAP=1 and OVERLAP=0 instances sharing the same stimulus.
module tb_fsm_moore_verilog;
    import fsm_moore_pkg::*;

    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    logic i_data_in = 1'b0;
    logic out_ov;
    logic out_nov;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 i_clock = ~i_clock;

    fsm_moore_verilog #(.OVERLAP(1)) dut_ov (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_data_in  (i_data_in),
        .o_data_out (out_ov)
    );

    fsm_moore_verilog #(.OVERLAP(0)) dut_nov (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_data_in  (i_data_in),
        .o_data_out (out_nov)
    );

    // Apply one bit (and reset level) across one rising edge, then settle.
    task automatic drive(input logic d, input logic r);
        i_data_in = d;
        i_reset   = r;
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 1'b1);
            n_checks++;
            if (out_ov !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_out_ov[%0d]: got %b expected 0", i, out_ov);
            end
            n_checks++;
            if (out_nov !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_out_nov[%0d]: got %b expected 0", i, out_nov);
            end
            n_checks++;
            if (dut_ov.state !== S_IDLE) begin
                n_fails++;
                $display("FAIL reset_state[%0d]: got %0d expected %0d", i, dut_ov.state, S_IDLE);
            end
        end
        i_reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [0:8] bits = 9'b1010_0101_0;
        logic [0:8] exp  = 9'b0001_0000_1;
        drive(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            drive(bits[i], 1'b0);
            n_checks++;
            if (out_ov !== exp[i]) begin
                n_fails++;
                $display("FAIL basic_ov[%0d]: got %b expected %b", i, out_ov, exp[i]);
            end
            n_checks++;
            if (out_nov !== exp[i]) begin
                n_fails++;
                $display("FAIL basic_nov[%0d]: got %b expected %b", i, out_nov, exp[i]);
            end
        end
    endtask

    task automatic test_overlap;
        logic [0:5] bits    = 6'b101010;
        logic [0:5] exp_ov  = 6'b000101;
        logic [0:5] exp_nov = 6'b000100;
        drive(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(bits[i], 1'b0);
            n_checks++;
            if (out_ov !== exp_ov[i]) begin
                n_fails++;
                $display("FAIL overlap_ov[%0d]: got %b expected %b", i, out_ov, exp_ov[i]);
            end
            n_checks++;
            if (out_nov !== exp_nov[i]) begin
                n_fails++;
                $display("FAIL overlap_nov[%0d]: got %b expected %b", i, out_nov, exp_nov[i]);
            end
        end
    endtask

    task automatic test_near_miss;
        logic [0:9] bits = 10'b1101_1001_00;
        state_t exp_st[10] = '{S_1, S_1, S_10, S_101, S_1, S_10, S_IDLE, S_1, S_10, S_IDLE};
        drive(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(bits[i], 1'b0);
            n_checks++;
            if (out_ov !== 1'b0 || out_nov !== 1'b0) begin
                n_fails++;
                $display("FAIL near_miss_out[%0d]: got ov=%b nov=%b expected 0", i, out_ov, out_nov);
            end
            n_checks++;
            if (dut_ov.state !== exp_st[i]) begin
                n_fails++;
                $display("FAIL near_miss_state[%0d]: got %0d expected %0d", i, dut_ov.state, exp_st[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [0:8] bits = 9'b101_0_0_1010;
        logic [0:8] rst  = 9'b000_1_0_0000;
        logic [0:8] exp  = 9'b000_0_0_0001;
        drive(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            drive(bits[i], rst[i]);
            n_checks++;
            if (out_ov !== exp[i]) begin
                n_fails++;
                $display("FAIL mid_reset_ov[%0d]: got %b expected %b", i, out_ov, exp[i]);
            end
            n_checks++;
            if (out_nov !== exp[i]) begin
                n_fails++;
                $display("FAIL mid_reset_nov[%0d]: got %b expected %b", i, out_nov, exp[i]);
            end
        end
    endtask

    // Reference: 4-bit history plus counts of fresh bits since reset / since last counted match.
    task automatic test_random;
        logic [3:0] sh = 4'b0;
        int cnt_ov = 0;
        int cnt_nov = 0;
        logic exp_ov;
        logic exp_nov;
        logic d;
        logic r;
        int shown = 0;
        for (int i = 0; i < 10000; i++) begin
            d = 1'($urandom_range(0, 1));
            r = (i == 0) || ($urandom_range(0, 63) == 0);
            if (r) begin
                sh = 4'b0;
                cnt_ov = 0;
                cnt_nov = 0;
                exp_ov = 1'b0;
                exp_nov = 1'b0;
            end else begin
                sh = {sh[2:0], d};
                cnt_ov = (cnt_ov < 4) ? cnt_ov + 1 : 4;
                cnt_nov = (cnt_nov < 4) ? cnt_nov + 1 : 4;
                exp_ov = (sh == PATTERN) && (cnt_ov >= 4);
                exp_nov = (sh == PATTERN) && (cnt_nov >= 4);
                if (exp_nov) cnt_nov = 0;
            end
            drive(d, r);
            n_checks++;
            if (out_ov !== exp_ov) begin
                n_fails++;
                if (shown < 10) $display("FAIL random_ov[%0d]: got %b expected %b", i, out_ov, exp_ov);
                shown++;
            end
            n_checks++;
            if (out_nov !== exp_nov) begin
                n_fails++;
                if (shown < 10) $display("FAIL random_nov[%0d]: got %b expected %b", i, out_nov, exp_nov);
                shown++;
            end
        end
        i_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_near_miss();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
